command_sequencer: RTL and testbench

//  Key-driven FSM directly upstream of the command decoder (Controler). Turns debounced keypad events

---
 rtl/calc_pkg.sv | 54 +++++
 rtl/cmd_emitter.sv | 59 +++++
 rtl/command_sequencer.sv | 150 +++++++++++++++
 tb/tb_command_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - command codes, key codes, FSM states and hold limits for the command sequencer
package calc_pkg;

    localparam int CMD_HOLD_MIN = 1;
    localparam int CMD_HOLD_MAX = 15;

    typedef enum logic [3:0] {
        CMD_CLR   = 4'd0,
        CMD_CLRLD = 4'd1,
        CMD_LOADX = 4'd2,
        CMD_ADD   = 4'd3,
        CMD_SUB   = 4'd4,
        CMD_MULT  = 4'd5,
        CMD_DIV   = 4'd6,
        CMD_MIN   = 4'd7,
        CMD_MAX   = 4'd8,
        CMD_DISP  = 4'd9,
        CMD_END   = 4'd10,
        CMD_NOP   = 4'd11
    } cmd_e;

    typedef enum logic [3:0] {
        KEY_NUM  = 4'd0,
        KEY_ADD  = 4'd1,
        KEY_SUB  = 4'd2,
        KEY_MULT = 4'd3,
        KEY_DIV  = 4'd4,
        KEY_MIN  = 4'd5,
        KEY_MAX  = 4'd6,
        KEY_EQ   = 4'd7,
        KEY_CLR  = 4'd8,
        KEY_OFF  = 4'd9
    } key_e;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_EMPTY  = 3'd1,
        ST_HAVE_X = 3'd2,
        ST_WAIT_B = 3'd3,
        ST_HAVE_B = 3'd4,
        ST_RESULT = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    // Operator keys ADD..MAX map onto the contiguous command codes ADD..MAX.
    function automatic logic [3:0] op_to_cmd(input logic [3:0] op);
        return op + 4'd2;
    endfunction

    function automatic logic is_op(input logic [3:0] key);
        return (key >= KEY_ADD) && (key <= KEY_MAX);
    endfunction

endpackage

// File: rtl/cmd_emitter.sv
// rtl/cmd_emitter.sv - two-slot command queue with per-command hold counter
module cmd_emitter #(
    parameter int HOLD = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       two_i,
    input  logic [3:0] cmd0_i,
    input  logic [3:0] cmd1_i,
    output logic [3:0] cmd_o,
    output logic       valid_o,
    output logic       busy_o
);
    import calc_pkg::*;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    logic       active_q;
    logic       two_q;
    logic [3:0] cur_q;
    logic [3:0] nxt_q;
    logic [3:0] cnt_q;

    // Load a 1- or 2-command burst, hold each slot HOLD cycles, then return to NOP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            two_q    <= 1'b0;
            cur_q    <= CMD_NOP;
            nxt_q    <= CMD_NOP;
            cnt_q    <= 4'd0;
        end else if (load_i) begin
            active_q <= 1'b1;
            two_q    <= two_i;
            cur_q    <= cmd0_i;
            nxt_q    <= cmd1_i;
            cnt_q    <= 4'd0;
        end else if (active_q) begin
            if (cnt_q == HOLD_LAST) begin
                cnt_q <= 4'd0;
                if (two_q) begin
                    cur_q <= nxt_q;
                    two_q <= 1'b0;
                end else begin
                    active_q <= 1'b0;
                    cur_q    <= CMD_NOP;
                end
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign cmd_o   = cur_q;
    assign valid_o = active_q;
    assign busy_o  = active_q;

endmodule

// File: rtl/command_sequencer.sv
// rtl/command_sequencer.sv - keypad-driven calculator FSM feeding Controler; SEQ_DROP_FLAG_EN adds keyDropped
module command_sequencer
    import calc_pkg::*;
#(
    parameter int CMD_HOLD = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       keyValid,
    input  logic [3:0] keyCode,
    output logic [3:0] comandSequencer,
    output logic       cmdValid,
    output logic       keyReady
`ifdef SEQ_DROP_FLAG_EN
    ,
    output logic       keyDropped
`endif
);

    // Out-of-range hold values are clamped into the legal 1..15 window.
    localparam int HOLD = (CMD_HOLD < CMD_HOLD_MIN) ? CMD_HOLD_MIN :
                          (CMD_HOLD > CMD_HOLD_MAX) ? CMD_HOLD_MAX : CMD_HOLD;

    state_e     state_q, state_d;
    logic [3:0] pend_q, pend_d;
    logic       load, two, busy, accept;
    logic [3:0] c0, c1;

    assign keyReady = !busy && (state_q != ST_INIT);
    assign accept   = keyValid && keyReady && (keyCode <= KEY_OFF);

    // State and pending-operator registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            pend_q  <= KEY_ADD;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Next state, pending operator and the command burst for the accepted key.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        load    = 1'b0;
        two     = 1'b0;
        c0      = CMD_NOP;
        c1      = CMD_NOP;
        if (state_q == ST_INIT) begin
            load    = 1'b1;
            c0      = CMD_CLR;
            state_d = ST_EMPTY;
        end else if (accept) begin
            if (keyCode == KEY_CLR) begin
                load    = 1'b1;
                c0      = CMD_CLR;
                state_d = ST_EMPTY;
                pend_d  = KEY_ADD;
            end else if (state_q == ST_HALT) begin
                state_d = ST_HALT;
            end else if (keyCode == KEY_OFF) begin
                load    = 1'b1;
                c0      = CMD_END;
                state_d = ST_HALT;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (keyCode == KEY_NUM) begin
                            load = 1'b1; c0 = CMD_CLRLD; state_d = ST_HAVE_X;
                        end
                    end
                    ST_HAVE_X: begin
                        if (keyCode == KEY_NUM) begin
                            load = 1'b1; c0 = CMD_LOADX;
                        end else if (is_op(keyCode)) begin
                            load = 1'b1; c0 = CMD_ADD; pend_d = keyCode; state_d = ST_WAIT_B;
                        end else begin
                            load = 1'b1; c0 = CMD_DISP; state_d = ST_RESULT;
                        end
                    end
                    ST_WAIT_B: begin
                        if (keyCode == KEY_NUM) begin
                            load = 1'b1; c0 = CMD_LOADX; state_d = ST_HAVE_B;
                        end else if (is_op(keyCode)) begin
                            pend_d = keyCode;
                        end else begin
                            load = 1'b1; c0 = CMD_DISP; state_d = ST_RESULT;
                        end
                    end
                    ST_HAVE_B: begin
                        if (keyCode == KEY_NUM) begin
                            load = 1'b1; c0 = CMD_LOADX;
                        end else begin
                            load = 1'b1; two = 1'b1;
                            c0   = op_to_cmd(pend_q);
                            c1   = CMD_DISP;
                            if (is_op(keyCode)) begin
                                pend_d = keyCode; state_d = ST_WAIT_B;
                            end else begin
                                state_d = ST_RESULT;
                            end
                        end
                    end
                    ST_RESULT: begin
                        if (keyCode == KEY_NUM) begin
                            load = 1'b1; c0 = CMD_CLRLD; state_d = ST_HAVE_X;
                        end else if (is_op(keyCode)) begin
                            pend_d = keyCode; state_d = ST_WAIT_B;
                        end else begin
                            load = 1'b1; c0 = CMD_DISP;
                        end
                    end
                    default: state_d = ST_EMPTY;
                endcase
            end
        end
    end

    cmd_emitter #(.HOLD(HOLD)) u_emitter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .two_i   (two),
        .cmd0_i  (c0),
        .cmd1_i  (c1),
        .cmd_o   (comandSequencer),
        .valid_o (cmdValid),
        .busy_o  (busy)
    );

`ifdef SEQ_DROP_FLAG_EN
    logic drop_q;

    // Sticky flag for well-formed keys that arrive while the sequencer is busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q <= 1'b0;
        end else if (keyValid && !keyReady && (keyCode <= KEY_OFF)) begin
            drop_q <= 1'b1;
        end else if (accept && (keyCode == KEY_CLR)) begin
            drop_q <= 1'b0;
        end
    end

    assign keyDropped = drop_q;
`endif

endmodule

// File: tb/tb_command_sequencer.sv
// tb/tb_command_sequencer.sv - directed self-checking bench for command_sequencer
module tb_command_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       kv1, kv3;
    logic [3:0] kc1, kc3;
    logic [3:0] c1, c3;
    logic       v1, v3, r1, r3;
`ifdef SEQ_DROP_FLAG_EN
    logic       kd1, kd3;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    command_sequencer #(.CMD_HOLD(1)) dut1 (
`ifdef SEQ_DROP_FLAG_EN
        .keyDropped      (kd1),
`endif
        .clk             (clk),
        .rst_n           (rst_n),
        .keyValid        (kv1),
        .keyCode         (kc1),
        .comandSequencer (c1),
        .cmdValid        (v1),
        .keyReady        (r1)
    );

    command_sequencer #(.CMD_HOLD(3)) dut3 (
`ifdef SEQ_DROP_FLAG_EN
        .keyDropped      (kd3),
`endif
        .clk             (clk),
        .rst_n           (rst_n),
        .keyValid        (kv3),
        .keyCode         (kc3),
        .comandSequencer (c3),
        .cmdValid        (v3),
        .keyReady        (r3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        kv1 = 1'b1; kc1 = code;
        tick();
        kv1 = 1'b0;
    endtask

    task automatic press3(input logic [3:0] code);
        kv3 = 1'b1; kc3 = code;
        tick();
        kv3 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; kv1 = 1'b0; kv3 = 1'b0; kc1 = 4'd0; kc3 = 4'd0;
        tick(); tick();
        n_checks++; if ({c1, v1, r1} !== 6'b1011_00) $display("FAIL reset_idle got %b exp %b", {c1, v1, r1}, 6'b1011_00); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++; if ({c1, v1, r1} !== 6'b0000_10) $display("FAIL init_clr1 got %b exp %b", {c1, v1, r1}, 6'b0000_10); else n_pass++;
        n_checks++; if ({c3, v3, r3} !== 6'b0000_10) $display("FAIL init_clr3 got %b exp %b", {c3, v3, r3}, 6'b0000_10); else n_pass++;
        tick();
        n_checks++; if ({c1, v1, r1} !== 6'b1011_01) $display("FAIL init_nop1 got %b exp %b", {c1, v1, r1}, 6'b1011_01); else n_pass++;
        n_checks++; if ({c3, v3, r3} !== 6'b0000_10) $display("FAIL init_hold3 got %b exp %b", {c3, v3, r3}, 6'b0000_10); else n_pass++;
        tick(); tick();
        n_checks++; if ({c3, v3, r3} !== 6'b1011_01) $display("FAIL init_nop3 got %b exp %b", {c3, v3, r3}, 6'b1011_01); else n_pass++;
    endtask

    task automatic test_chain_add;
        press(4'd0);
        n_checks++; if ({c1, v1, r1} !== 6'b0001_10) $display("FAIL add_clrld got %b exp %b", {c1, v1, r1}, 6'b0001_10); else n_pass++;
        tick();
        press(4'd1);
        n_checks++; if ({c1, v1, r1} !== 6'b0011_10) $display("FAIL add_op got %b exp %b", {c1, v1, r1}, 6'b0011_10); else n_pass++;
        tick();
        press(4'd0);
        n_checks++; if ({c1, v1, r1} !== 6'b0010_10) $display("FAIL add_loadx got %b exp %b", {c1, v1, r1}, 6'b0010_10); else n_pass++;
        tick();
        press(4'd7);
        n_checks++; if ({c1, v1, r1} !== 6'b0011_10) $display("FAIL add_eq_op got %b exp %b", {c1, v1, r1}, 6'b0011_10); else n_pass++;
        tick();
        n_checks++; if ({c1, v1, r1} !== 6'b1001_10) $display("FAIL add_eq_disp got %b exp %b", {c1, v1, r1}, 6'b1001_10); else n_pass++;
        tick();
        n_checks++; if ({c1, v1, r1} !== 6'b1011_01) $display("FAIL add_eq_idle got %b exp %b", {c1, v1, r1}, 6'b1011_01); else n_pass++;
        press(4'd7);
        n_checks++; if ({c1, v1, r1} !== 6'b1001_10) $display("FAIL result_eq got %b exp %b", {c1, v1, r1}, 6'b1001_10); else n_pass++;
        tick();
        press(4'd0);
        n_checks++; if ({c1, v1, r1} !== 6'b0001_10) $display("FAIL result_num got %b exp %b", {c1, v1, r1}, 6'b0001_10); else n_pass++;
        tick();
        press(4'd8);
        n_checks++; if ({c1, v1, r1} !== 6'b0000_10) $display("FAIL add_clr got %b exp %b", {c1, v1, r1}, 6'b0000_10); else n_pass++;
        tick();
    endtask

    task automatic test_op_replace;
        press(4'd0); tick();
        press(4'd2);
        n_checks++; if ({c1, v1, r1} !== 6'b0011_10) $display("FAIL rep_first_op got %b exp %b", {c1, v1, r1}, 6'b0011_10); else n_pass++;
        tick();
        press(4'd3);
        n_checks++; if ({c1, v1, r1} !== 6'b1011_01) $display("FAIL rep_silent got %b exp %b", {c1, v1, r1}, 6'b1011_01); else n_pass++;
        press(4'd0);
        n_checks++; if ({c1, v1, r1} !== 6'b0010_10) $display("FAIL rep_loadx got %b exp %b", {c1, v1, r1}, 6'b0010_10); else n_pass++;
        tick();
        press(4'd7);
        n_checks++; if ({c1, v1, r1} !== 6'b0101_10) $display("FAIL rep_mult got %b exp %b", {c1, v1, r1}, 6'b0101_10); else n_pass++;
        tick();
        n_checks++; if ({c1, v1, r1} !== 6'b1001_10) $display("FAIL rep_disp got %b exp %b", {c1, v1, r1}, 6'b1001_10); else n_pass++;
        tick();
        press(4'd8); tick();
    endtask

    task automatic test_chain_ops;
        press(4'd0); tick();
        press(4'd1); tick();
        press(4'd0); tick();
        press(4'd2);
        n_checks++; if ({c1, v1, r1} !== 6'b0011_10) $display("FAIL chain_add got %b exp %b", {c1, v1, r1}, 6'b0011_10); else n_pass++;
        tick();
        n_checks++; if ({c1, v1, r1} !== 6'b1001_10) $display("FAIL chain_disp got %b exp %b", {c1, v1, r1}, 6'b1001_10); else n_pass++;
        tick();
        press(4'd0); tick();
        press(4'd7);
        n_checks++; if ({c1, v1, r1} !== 6'b0100_10) $display("FAIL chain_sub got %b exp %b", {c1, v1, r1}, 6'b0100_10); else n_pass++;
        tick(); tick();
        press(4'd8); tick();
    endtask

    task automatic test_hold3;
        logic [3:0] exp_c [7];
        exp_c = '{4'd6, 4'd6, 4'd6, 4'd9, 4'd9, 4'd9, 4'd11};
        press3(4'd0); repeat (3) tick();
        press3(4'd4); repeat (3) tick();
        press3(4'd0); repeat (3) tick();
        press3(4'd7);
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if ({c3, v3, r3} !== {exp_c[i], (i < 6) ? 2'b10 : 2'b01})
                $display("FAIL hold3_cycle%0d got %b exp %b", i, {c3, v3, r3}, {exp_c[i], (i < 6) ? 2'b10 : 2'b01});
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_drop;
        press(4'd0);
        kv1 = 1'b1; kc1 = 4'd7;
        tick();
        kv1 = 1'b0;
        n_checks++; if ({c1, v1, r1} !== 6'b1011_01) $display("FAIL drop_ignored got %b exp %b", {c1, v1, r1}, 6'b1011_01); else n_pass++;
`ifdef SEQ_DROP_FLAG_EN
        n_checks++; if (kd1 !== 1'b1) $display("FAIL drop_flag_set got %b exp 1", kd1); else n_pass++;
`endif
        press(4'd7);
        n_checks++; if ({c1, v1, r1} !== 6'b1001_10) $display("FAIL drop_state got %b exp %b", {c1, v1, r1}, 6'b1001_10); else n_pass++;
        tick();
        press(4'd12);
        n_checks++; if ({c1, v1, r1} !== 6'b1011_01) $display("FAIL bad_code got %b exp %b", {c1, v1, r1}, 6'b1011_01); else n_pass++;
        press(4'd0);
        n_checks++; if ({c1, v1, r1} !== 6'b0001_10) $display("FAIL bad_code_state got %b exp %b", {c1, v1, r1}, 6'b0001_10); else n_pass++;
        tick();
        press(4'd8); tick();
`ifdef SEQ_DROP_FLAG_EN
        n_checks++; if (kd1 !== 1'b0) $display("FAIL drop_flag_clr got %b exp 0", kd1); else n_pass++;
`endif
    endtask

    task automatic test_halt;
        press(4'd9);
        n_checks++; if ({c1, v1, r1} !== 6'b1010_10) $display("FAIL off_end got %b exp %b", {c1, v1, r1}, 6'b1010_10); else n_pass++;
        tick();
        press(4'd0);
        n_checks++; if ({c1, v1, r1} !== 6'b1011_01) $display("FAIL halt_num got %b exp %b", {c1, v1, r1}, 6'b1011_01); else n_pass++;
        press(4'd7);
        n_checks++; if ({c1, v1, r1} !== 6'b1011_01) $display("FAIL halt_eq got %b exp %b", {c1, v1, r1}, 6'b1011_01); else n_pass++;
        press(4'd8);
        n_checks++; if ({c1, v1, r1} !== 6'b0000_10) $display("FAIL halt_clr got %b exp %b", {c1, v1, r1}, 6'b0000_10); else n_pass++;
        tick();
        press(4'd0);
        n_checks++; if ({c1, v1, r1} !== 6'b0001_10) $display("FAIL halt_empty got %b exp %b", {c1, v1, r1}, 6'b0001_10); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid;
        press3(4'd8); repeat (3) tick();
        press3(4'd0); repeat (3) tick();
        press3(4'd7);
        tick();
        n_checks++; if ({c3, v3, r3} !== 6'b1001_10) $display("FAIL mid_disp got %b exp %b", {c3, v3, r3}, 6'b1001_10); else n_pass++;
        rst_n = 1'b0;
        tick();
        n_checks++; if ({c3, v3, r3} !== 6'b1011_00) $display("FAIL mid_reset got %b exp %b", {c3, v3, r3}, 6'b1011_00); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++; if ({c3, v3, r3} !== 6'b0000_10) $display("FAIL mid_reinit got %b exp %b", {c3, v3, r3}, 6'b0000_10); else n_pass++;
        repeat (3) tick();
        n_checks++; if ({c3, v3, r3} !== 6'b1011_01) $display("FAIL mid_idle got %b exp %b", {c3, v3, r3}, 6'b1011_01); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_chain_add();
        test_op_replace();
        test_chain_ops();
        test_hold3();
        test_drop();
        test_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
